// File: rtl/mul_issue_collect.sv
// Issue/collect shell around the fixed-latency vedic multiplier: registers requests onto the
// multiplier inputs, tracks each op through a tag pipe and queues results in issue order.
module mul_issue_collect #(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 3,
    parameter int DEPTH       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_operand_a,
    input  logic [WIDTH-1:0] in_operand_b,
    input  logic [1:0]       in_opcode,
    input  logic [1:0]       in_precision,
    output logic [WIDTH-1:0] mul_operand_a,
    output logic [WIDTH-1:0] mul_operand_b,
    output logic [1:0]       mul_opcode,
    output logic [1:0]       mul_precision,
    input  logic [WIDTH-1:0] mul_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_err,
    output logic [2:0]       inflight
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
    // Valid never waits on ready; ready never looks at the partner's valid.
    logic issue;
    logic pop;
    logic push;
    logic push_err;

    logic [MUL_LATENCY-1:0] tag_v;
    logic [MUL_LATENCY-1:0] tag_e;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    fifo_count;
    logic             fifo_empty;
    logic [3:0]       credit_used;

    logic [WIDTH-1:0] res_mem [DEPTH];
    logic [DEPTH-1:0] err_mem;

    assign fifo_count  = wr_ptr - rd_ptr;
    assign fifo_empty  = (wr_ptr == rd_ptr);
    // Every slot is reserved at issue time, so a captured result always finds room.
    assign credit_used = 4'(inflight) + 4'(fifo_count);
    assign in_ready    = !rst && (credit_used < 4'(DEPTH));

    assign issue    = in_valid && in_ready;
    assign push     = tag_v[MUL_LATENCY-1];
    assign push_err = tag_e[MUL_LATENCY-1];
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    assign out_result = fifo_empty ? '0   : res_mem[rd_ptr[AW-1:0]];
    assign out_err    = fifo_empty ? 1'b0 : err_mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_operand_a <= '0;
            mul_operand_b <= '0;
            mul_opcode    <= '0;
            mul_precision <= '0;
        end else if (issue) begin
            mul_operand_a <= in_operand_a;
            mul_operand_b <= in_operand_b;
            mul_opcode    <= in_opcode;
            mul_precision <= in_precision;
        end
    end

    // One stage per multiplier clock; the tag leaving the last stage lines up with mul_result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v <= '0;
            tag_e <= '0;
        end else begin
            tag_v[0] <= issue;
            tag_e[0] <= issue && (in_precision == 2'b11);
            for (int i = 1; i < MUL_LATENCY; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_e[i] <= tag_e[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({issue, push})
                2'b10:   inflight <= inflight + 3'd1;
                2'b01:   inflight <= inflight - 3'd1;
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: reads are masked while the pointers say empty.
    always_ff @(posedge clk) begin
        if (push) begin
            res_mem[wr_ptr[AW-1:0]] <= push_err ? '0 : mul_result;
            err_mem[wr_ptr[AW-1:0]] <= push_err;
        end
    end

endmodule

// File: tb/tb_mul_issue_collect.sv
// Directed bench for mul_issue_collect with a behavioural 3-cycle multiplier and an in-order scoreboard.
module tb_mul_issue_collect;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_operand_a;
    logic [31:0] in_operand_b;
    logic [1:0]  in_opcode;
    logic [1:0]  in_precision;
    logic [31:0] mul_operand_a;
    logic [31:0] mul_operand_b;
    logic [1:0]  mul_opcode;
    logic [1:0]  mul_precision;
    logic [31:0] mul_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_err;
    logic [2:0]  inflight;

    int total = 0;
    int bad = 0;
    int push_cnt = 0;
    int pop_cnt = 0;
    int acc;
    logic [32:0] exp_q[$];
    logic [31:0] mdl_s1 = '0;
    logic [31:0] mdl_s2 = '0;

    mul_issue_collect #(.WIDTH(32), .MUL_LATENCY(3), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_operand_a(in_operand_a), .in_operand_b(in_operand_b),
        .in_opcode(in_opcode), .in_precision(in_precision),
        .mul_operand_a(mul_operand_a), .mul_operand_b(mul_operand_b),
        .mul_opcode(mul_opcode), .mul_precision(mul_precision),
        .mul_result(mul_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_err(out_err),
        .inflight(inflight)
    );

    // Clock / reset-independent watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    // Behavioural multiplier: unsigned lane products, opcode 10 selects the high half
    function automatic logic [31:0] mul_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] op, input logic [1:0] prec);
        logic [31:0] r;
        logic [15:0] p8;
        logic [31:0] p16;
        logic [63:0] p32;
        r = '0;
        case (prec)
            2'b00: for (int l = 0; l < 4; l++) begin
                p8 = 16'(a[l*8 +: 8]) * 16'(b[l*8 +: 8]);
                r[l*8 +: 8] = (op == 2'b10) ? p8[15:8] : p8[7:0];
            end
            2'b01: for (int l = 0; l < 2; l++) begin
                p16 = 32'(a[l*16 +: 16]) * 32'(b[l*16 +: 16]);
                r[l*16 +: 16] = (op == 2'b10) ? p16[31:16] : p16[15:0];
            end
            2'b10: begin
                p32 = 64'(a) * 64'(b);
                r = (op == 2'b10) ? p32[63:32] : p32[31:0];
            end
            default: r = 32'hDEADBEEF;
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        mdl_s1 <= mul_model(mul_operand_a, mul_operand_b, mul_opcode, mul_precision);
        mdl_s2 <= mdl_s1;
    end
    assign mul_result = mdl_s2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: a result handshake is predicted at the negedge before the edge that completes it
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            pop_cnt++;
            if (exp_q.size() == 0) chk("unexpected_result", 64'({out_err, out_result}), 64'h1_FFFF_FFFF_F);
            else chk("result_order", 64'({out_err, out_result}), 64'(exp_q.pop_front()));
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic [1:0] prec);
        bit done;
        done = 0;
        in_operand_a = a;
        in_operand_b = b;
        in_opcode    = op;
        in_precision = prec;
        in_valid     = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            if (in_ready) done = 1;
            tick();
        end
        in_valid = 1'b0;
        if (!done) chk("issue_timeout", 64'd0, 64'd1);
    endtask

    task automatic expect_res(input logic err, input logic [31:0] res);
        exp_q.push_back({err, res});
        push_cnt++;
    endtask

    // Holds in_valid for n cycles with a = base+i, b = 3; accepted ops expect 3*(base+i)
    task automatic stream(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            in_operand_a = 32'(base + i);
            in_operand_b = 32'd3;
            in_opcode    = 2'b00;
            in_precision = 2'b10;
            in_valid     = 1'b1;
            if (in_ready) begin
                expect_res(1'b0, 32'(3 * (base + i)));
                acc++;
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int n = 0; n < 40; n++) begin
            if (exp_q.size() == 0 && inflight == 0 && !out_valid) break;
            tick();
        end
        chk(tag, 64'({32'(exp_q.size()), 29'd0, inflight}), 64'd0);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_operand_a = '0;
        in_operand_b = '0;
        in_opcode = '0;
        in_precision = '0;
        out_ready = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_result", 64'(out_result), 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);
        chk("rst_inflight", 64'(inflight), 64'd0);
        chk("rst_mul", 64'({mul_operand_a, mul_operand_b[27:0], mul_opcode, mul_precision}), 64'd0);
        rst = 1'b0;
        tick();
        chk("idle_in_ready", 64'(in_ready), 64'd1);

        // 1: 32-bit high half, exact latency
        out_ready = 1'b1;
        expect_res(1'b0, 32'h00000001);
        issue(32'h00000002, 32'hFFFFFFFE, 2'b10, 2'b10);
        chk("t1_mul_a", 64'(mul_operand_a), 64'h00000002);
        chk("t1_mul_b", 64'(mul_operand_b), 64'hFFFFFFFE);
        chk("t1_mul_ctl", 64'({mul_opcode, mul_precision}), 64'hA);
        chk("t1_inflight", 64'(inflight), 64'd1);
        chk("t1_valid_t0", 64'(out_valid), 64'd0);
        tick();
        chk("t1_valid_t1", 64'(out_valid), 64'd0);
        tick();
        chk("t1_valid_t2", 64'(out_valid), 64'd0);
        tick();
        chk("t1_valid_t3", 64'(out_valid), 64'd1);
        chk("t1_result", 64'(out_result), 64'h00000001);
        chk("t1_err", 64'(out_err), 64'd0);
        tick();
        chk("t1_after_pop", 64'({out_valid, inflight}), 64'd0);

        // 2: 4x8b lanes high half
        expect_res(1'b0, 32'h01010101);
        issue(32'h02020202, 32'hFEFEFEFE, 2'b10, 2'b00);
        wait_drain("t2_drain");

        // 3: consumer stalled, credit limit of 4
        out_ready = 1'b0;
        acc = 0;
        stream(6, 3);
        chk("t3_accepted", 64'(acc), 64'd4);
        chk("t3_in_ready_full", 64'(in_ready), 64'd0);
        tick();
        chk("t3_inflight_zero", 64'(inflight), 64'd0);
        chk("t3_still_blocked", 64'(in_ready), 64'd0);
        chk("t3_head", 64'({out_valid, out_err, out_result}), 64'({2'b10, 32'd9}));
        tick();
        chk("t3_head_stable", 64'({out_valid, out_err, out_result}), 64'({2'b10, 32'd9}));
        out_ready = 1'b1;
        #1;
        chk("t3_ready_not_comb", 64'(in_ready), 64'd0);
        tick();
        chk("t3_ready_after_pop", 64'(in_ready), 64'd1);
        wait_drain("t3_drain");

        // 4: full FIFO then continuous traffic both sides
        out_ready = 1'b0;
        acc = 0;
        stream(6, 8);
        tick();
        chk("t4_full", 64'({in_ready, out_valid, inflight}), 64'({2'b01, 3'd0}));
        out_ready = 1'b1;
        acc = 0;
        stream(12, 20);
        chk("t4_accepted_some", 64'(acc >= 6), 64'd1);
        wait_drain("t4_drain");
        chk("t4_pop_vs_push", 64'(pop_cnt), 64'(push_cnt));

        // 5: reserved precision forces zero with err, next op clean
        expect_res(1'b1, 32'h0);
        issue(32'h12345678, 32'h9ABCDEF0, 2'b10, 2'b11);
        chk("t5_mul_prec", 64'(mul_precision), 64'd3);
        expect_res(1'b0, 32'h00000002);
        issue(32'h80000000, 32'h00000004, 2'b10, 2'b10);
        wait_drain("t5_drain");

        // 6: asynchronous reset with 2 in flight and 2 queued
        out_ready = 1'b0;
        issue(32'h11, 32'h2, 2'b00, 2'b10);
        issue(32'h12, 32'h2, 2'b00, 2'b10);
        issue(32'h13, 32'h2, 2'b00, 2'b10);
        issue(32'h14, 32'h2, 2'b00, 2'b10);
        tick();
        chk("t6_pre_inflight", 64'(inflight), 64'd2);
        chk("t6_pre_valid", 64'(out_valid), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_async_outs", 64'({out_valid, out_err, in_ready, inflight}), 64'd0);
        chk("t6_async_result", 64'(out_result), 64'd0);
        chk("t6_async_mul", 64'(mul_operand_a), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t6_no_stale", 64'({out_valid, inflight}), 64'd0);
        end
        expect_res(1'b0, 32'h00000001);
        issue(32'h00000002, 32'hFFFFFFFE, 2'b10, 2'b10);
        wait_drain("t6_post_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
